// File: rtl/regfile_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// asip_rf_pkg
// Purpose : shared widths and types for the register-file port arbiter and
//           its requesters (16 x 32-bit register file).
// Contents: REG_ADDR_W / REG_DATA_W widths, rf_addr_t / rf_data_t types.
// ---------------------------------------------------------------------------
package asip_rf_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 16;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    typedef logic [REG_ADDR_W-1:0] rf_addr_t;
    typedef logic [REG_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter_if
// Purpose : request/response bundle between the pipeline requesters and the
//           register-file port arbiter.
// Signals : rd_valid/rd_addr/rd_ready      read request handshake (packed)
//           rd_rsp_valid/rd_rsp_data       registered read response
//           wr_valid/wr_addr/wr_data/wr_ready  write request handshake (packed)
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface regfile_port_arbiter_if #(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    import asip_rf_pkg::*;

    logic [NUM_RD-1:0]            rd_valid;
    logic [NUM_RD*REG_ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]            rd_ready;
    logic [NUM_RD-1:0]            rd_rsp_valid;
    rf_data_t                     rd_rsp_data;

    logic [NUM_WR-1:0]            wr_valid;
    logic [NUM_WR*REG_ADDR_W-1:0] wr_addr;
    logic [NUM_WR*REG_DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]            wr_ready;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready
    );

endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purpose : N-way round-robin arbiter with a combinational one-hot grant.
// Ports   : clk, reset (async, active-low)
//           req[N]      request lines
//           advance     a grant is being consumed this cycle
//           grant[N]    one-hot grant (zero when no request)
//           grant_idx   index of the granted requester
// The search starts at ptr_q; after a consumed grant to g the pointer moves
// to (g+1) mod N, otherwise it holds.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    // First requester found walking from ptr_q wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // The winner moves to the back of the queue; wrap explicitly for non-power-of-2 N.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            if (int'(grant_idx) == N - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_port_arbiter
// Purpose : shares the single read and single write port of the 16x32
//           register file among NUM_RD readers and NUM_WR writers.
// Ports   : clk, reset (async, active-low)
//           req_if          requester bundle (slave side)
//           rf_read_reg     -> Registers.readRegister
//           rf_read_value   <- Registers.readValue (combinational)
//           rf_write_en     write strobe
//           rf_write_reg    -> Registers.writeRegister
//           rf_write_value  -> Registers.writeValue
// Read data is registered one cycle after accept; a same-cycle write to the
// same register is forwarded into the response (write-first).
// ---------------------------------------------------------------------------
module regfile_port_arbiter
    import asip_rf_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    regfile_port_arbiter_if.slave         req_if,
    output rf_addr_t                      rf_read_reg,
    input  rf_data_t                      rf_read_value,
    output logic                          rf_write_en,
    output rf_addr_t                      rf_write_reg,
    output rf_data_t                      rf_write_value
);

    localparam int RD_IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WR_IW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [NUM_RD-1:0] rd_req;
    logic [NUM_RD-1:0] rd_grant;
    logic [RD_IW-1:0]  rd_idx;
    logic              rd_any;
    logic [NUM_WR-1:0] wr_req;
    logic [NUM_WR-1:0] wr_grant;
    logic [WR_IW-1:0]  wr_idx;
    logic              wr_any;

    logic [NUM_RD-1:0] rsp_valid_q;
    logic [NUM_RD-1:0] rsp_valid_d;
    rf_data_t          rsp_data_q;
    rf_data_t          rsp_data_d;

    // Requests are masked while reset is held so no grant or strobe leaks out.
    assign rd_req = req_if.rd_valid & {NUM_RD{reset}};
    assign wr_req = req_if.wr_valid & {NUM_WR{reset}};

    rr_arbiter #(.N(NUM_RD), .IW(RD_IW)) u_rd_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (rd_req),
        .advance   (|rd_req),
        .grant     (rd_grant),
        .grant_idx (rd_idx)
    );

    rr_arbiter #(.N(NUM_WR), .IW(WR_IW)) u_wr_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (wr_req),
        .advance   (|wr_req),
        .grant     (wr_grant),
        .grant_idx (wr_idx)
    );

    assign rd_any = |rd_grant;
    assign wr_any = |wr_grant;

    assign req_if.rd_ready     = rd_grant;
    assign req_if.wr_ready     = wr_grant;
    assign req_if.rd_rsp_valid = rsp_valid_q;
    assign req_if.rd_rsp_data  = rsp_data_q;
    assign rf_write_en         = wr_any;

    // Steer the granted payloads onto the register-file ports, zero when idle.
    always_comb begin
        rf_read_reg    = '0;
        rf_write_reg   = '0;
        rf_write_value = '0;
        if (rd_any) begin
            rf_read_reg = req_if.rd_addr[int'(rd_idx)*REG_ADDR_W +: REG_ADDR_W];
        end
        if (wr_any) begin
            rf_write_reg   = req_if.wr_addr[int'(wr_idx)*REG_ADDR_W +: REG_ADDR_W];
            rf_write_value = req_if.wr_data[int'(wr_idx)*REG_DATA_W +: REG_DATA_W];
        end
    end

    // The register file commits writes at the same edge we capture read data,
    // so its read port still shows the old value; forward the write instead.
    always_comb begin
        rsp_valid_d = rd_grant;
        rsp_data_d  = rsp_data_q;
        if (rd_any) begin
            if (wr_any && (rf_write_reg == rf_read_reg)) begin
                rsp_data_d = rf_write_value;
            end else begin
                rsp_data_d = rf_read_value;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_port_arbiter
// Purpose : directed self-checking bench for regfile_port_arbiter with a
//           behavioural 16x32 register file attached to the RF ports.
// ---------------------------------------------------------------------------
module tb_regfile_port_arbiter;
    import asip_rf_pkg::*;

    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic     clk;
    logic     reset;
    rf_addr_t rf_read_reg;
    rf_data_t rf_read_value;
    logic     rf_write_en;
    rf_addr_t rf_write_reg;
    rf_data_t rf_write_value;

    int n_tests;
    int n_fail;

    rf_data_t rf_mem [16];

    regfile_port_arbiter_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) req_if ();

    regfile_port_arbiter #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_if         (req_if.slave),
        .rf_read_reg    (rf_read_reg),
        .rf_read_value  (rf_read_value),
        .rf_write_en    (rf_write_en),
        .rf_write_reg   (rf_write_reg),
        .rf_write_value (rf_write_value)
    );

    // Clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural register file: combinational read, write at the clock edge.
    assign rf_read_value = rf_mem[rf_read_reg];
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_reg] <= rf_write_value;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_if.rd_valid = '0;
        req_if.rd_addr  = '0;
        req_if.wr_valid = '0;
        req_if.wr_addr  = '0;
        req_if.wr_data  = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // Reset and idle outputs.
    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        #3;
        n_tests++; if (req_if.rd_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rd_ready got %b want 00", req_if.rd_ready); end
        n_tests++; if (req_if.wr_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_wr_ready got %b want 00", req_if.wr_ready); end
        n_tests++; if (req_if.rd_rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %b want 00", req_if.rd_rsp_valid); end
        n_tests++; if (req_if.rd_rsp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_data got %h want 0", req_if.rd_rsp_data); end
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_write_en got %b want 0", rf_write_en); end
        n_tests++; if (rf_read_reg !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_read_reg got %h want 0", rf_read_reg); end
        n_tests++; if (rf_write_reg !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_write_reg got %h want 0", rf_write_reg); end
        n_tests++; if (rf_write_value !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_write_value got %h want 0", rf_write_value); end
        step();
        reset = 1'b1;
        step();
        n_tests++; if (req_if.rd_rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_rsp_valid got %b want 00", req_if.rd_rsp_valid); end
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_write_en got %b want 0", rf_write_en); end
    endtask

    // Single read from requester 0.
    task automatic test_single_read();
        rf_mem[5] = 32'hDEADBEEF;
        req_if.rd_valid = 2'b01;
        req_if.rd_addr  = {4'd0, 4'd5};
        #1;
        n_tests++; if (req_if.rd_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL single_rd_ready got %b want 01", req_if.rd_ready); end
        n_tests++; if (rf_read_reg !== 4'd5) begin n_fail++; $display("[TB] FAIL single_read_reg got %h want 5", rf_read_reg); end
        step();
        req_if.rd_valid = 2'b00;
        n_tests++; if (req_if.rd_rsp_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL single_rsp_valid got %b want 01", req_if.rd_rsp_valid); end
        n_tests++; if (req_if.rd_rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL single_rsp_data got %h want deadbeef", req_if.rd_rsp_data); end
        step();
        n_tests++; if (req_if.rd_rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL single_rsp_pulse got %b want 00", req_if.rd_rsp_valid); end
    endtask

    // Both readers contend: grants alternate starting from requester 0.
    task automatic test_read_contention();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_data;
        apply_reset();
        rf_mem[1] = 32'h11111111;
        rf_mem[2] = 32'h22222222;
        req_if.rd_addr  = {4'd2, 4'd1};
        req_if.rd_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_data = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
            #1;
            n_tests++; if (req_if.rd_ready !== exp_gnt) begin n_fail++; $display("[TB] FAIL contention_grant[%0d] got %b want %b", i, req_if.rd_ready, exp_gnt); end
            step();
            n_tests++; if (req_if.rd_rsp_valid !== exp_gnt) begin n_fail++; $display("[TB] FAIL contention_rsp_valid[%0d] got %b want %b", i, req_if.rd_rsp_valid, exp_gnt); end
            n_tests++; if (req_if.rd_rsp_data !== exp_data) begin n_fail++; $display("[TB] FAIL contention_rsp_data[%0d] got %h want %h", i, req_if.rd_rsp_data, exp_data); end
        end
        req_if.rd_valid = 2'b00;
    endtask

    // Both writers contend; pointer wraps back to requester 0.
    task automatic test_write_contention();
        req_if.wr_addr  = {4'd4, 4'd3};
        req_if.wr_data  = {32'hFFFFFFFF, 32'h0000FFFF};
        req_if.wr_valid = 2'b11;
        #1;
        n_tests++; if (req_if.wr_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL wr_first_ready got %b want 01", req_if.wr_ready); end
        n_tests++; if (rf_write_en !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_first_en got %b want 1", rf_write_en); end
        n_tests++; if (rf_write_reg !== 4'd3) begin n_fail++; $display("[TB] FAIL wr_first_reg got %h want 3", rf_write_reg); end
        n_tests++; if (rf_write_value !== 32'h0000FFFF) begin n_fail++; $display("[TB] FAIL wr_first_value got %h want 0000ffff", rf_write_value); end
        step();
        req_if.wr_valid = 2'b10;
        #1;
        n_tests++; if (req_if.wr_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL wr_second_ready got %b want 10", req_if.wr_ready); end
        n_tests++; if (rf_write_reg !== 4'd4) begin n_fail++; $display("[TB] FAIL wr_second_reg got %h want 4", rf_write_reg); end
        n_tests++; if (rf_write_value !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL wr_second_value got %h want ffffffff", rf_write_value); end
        step();
        req_if.wr_valid = 2'b00;
        n_tests++; if (rf_mem[3] !== 32'h0000FFFF) begin n_fail++; $display("[TB] FAIL wr_commit_r3 got %h want 0000ffff", rf_mem[3]); end
        n_tests++; if (rf_mem[4] !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL wr_commit_r4 got %h want ffffffff", rf_mem[4]); end
        #1;
        n_tests++; if (rf_write_en !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_idle_en got %b want 0", rf_write_en); end
        req_if.wr_valid = 2'b11;
        #1;
        n_tests++; if (req_if.wr_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL wr_wrap_ready got %b want 01", req_if.wr_ready); end
        step();
        req_if.wr_valid = 2'b00;
    endtask

    // Same-cycle read and write of r7: response carries the new value.
    task automatic test_bypass();
        rf_mem[7] = 32'h0;
        req_if.rd_addr  = {4'd0, 4'd7};
        req_if.wr_addr  = {4'd0, 4'd7};
        req_if.wr_data  = {32'h0, 32'h12345678};
        req_if.rd_valid = 2'b01;
        req_if.wr_valid = 2'b01;
        #1;
        n_tests++; if (req_if.rd_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL bypass_rd_ready got %b want 01", req_if.rd_ready); end
        n_tests++; if (req_if.wr_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL bypass_wr_ready got %b want 01", req_if.wr_ready); end
        step();
        drive_idle();
        n_tests++; if (req_if.rd_rsp_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL bypass_rsp_valid got %b want 01", req_if.rd_rsp_valid); end
        n_tests++; if (req_if.rd_rsp_data !== 32'h12345678) begin n_fail++; $display("[TB] FAIL bypass_rsp_data got %h want 12345678", req_if.rd_rsp_data); end
        n_tests++; if (rf_mem[7] !== 32'h12345678) begin n_fail++; $display("[TB] FAIL bypass_commit got %h want 12345678", rf_mem[7]); end
    endtask

    // A lone requester is granted every cycle.
    task automatic test_back_to_back();
        logic [3:0]  addr;
        logic [31:0] exp_data;
        req_if.rd_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin addr = 4'd3; exp_data = 32'h0000FFFF; end
                1:       begin addr = 4'd4; exp_data = 32'hFFFFFFFF; end
                default: begin addr = 4'd5; exp_data = 32'hDEADBEEF; end
            endcase
            req_if.rd_addr = {addr, 4'd0};
            #1;
            n_tests++; if (req_if.rd_ready !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_ready[%0d] got %b want 10", i, req_if.rd_ready); end
            step();
            n_tests++; if (req_if.rd_rsp_valid !== 2'b10) begin n_fail++; $display("[TB] FAIL b2b_rsp_valid[%0d] got %b want 10", i, req_if.rd_rsp_valid); end
            n_tests++; if (req_if.rd_rsp_data !== exp_data) begin n_fail++; $display("[TB] FAIL b2b_rsp_data[%0d] got %h want %h", i, req_if.rd_rsp_data, exp_data); end
        end
        req_if.rd_valid = 2'b00;
    endtask

    // Reset lands between an accept and its response edge.
    task automatic test_reset_mid_op();
        // Move both pointers to 1 first so the post-reset check means something.
        req_if.rd_valid = 2'b01;
        req_if.rd_addr  = {4'd0, 4'd5};
        req_if.wr_valid = 2'b01;
        req_if.wr_addr  = {4'd0, 4'd9};
        req_if.wr_data  = {32'h0, 32'hA5A5A5A5};
        step();
        drive_idle();
        n_tests++; if (req_if.rd_rsp_valid !== 2'b01) begin n_fail++; $display("[TB] FAIL midrst_pre_rsp got %b want 01", req_if.rd_rsp_valid); end
        step();
        req_if.rd_valid = 2'b01;
        req_if.rd_addr  = {4'd0, 4'd5};
        #1;
        n_tests++; if (req_if.rd_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL midrst_accept got %b want 01", req_if.rd_ready); end
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (req_if.rd_rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_async_valid got %b want 00", req_if.rd_rsp_valid); end
        n_tests++; if (req_if.rd_rsp_data !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_async_data got %h want 0", req_if.rd_rsp_data); end
        n_tests++; if (req_if.rd_ready !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_ready got %b want 00", req_if.rd_ready); end
        drive_idle();
        step();
        n_tests++; if (req_if.rd_rsp_valid !== 2'b00) begin n_fail++; $display("[TB] FAIL midrst_edge_valid got %b want 00", req_if.rd_rsp_valid); end
        reset = 1'b1;
        #1;
        req_if.rd_valid = 2'b11;
        req_if.wr_valid = 2'b11;
        #1;
        n_tests++; if (req_if.rd_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL midrst_rd_ptr got %b want 01", req_if.rd_ready); end
        n_tests++; if (req_if.wr_ready !== 2'b01) begin n_fail++; $display("[TB] FAIL midrst_wr_ptr got %b want 01", req_if.wr_ready); end
        step();
        drive_idle();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) rf_mem[i] = 32'h0;
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_read_contention();
        test_write_contention();
        test_bypass();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
